// File: rtl/idex_stage_if.sv
// idex_stage_if: decode/bypass/ALU-side bundle for idex_stage (build option IDEX_FWD_EN lives in idex_stage).
// master = decode/ALU environment driving the stage, slave = the stage itself.
interface idex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_alu_ctrl;
  logic [RA_W-1:0] in_rs1;
  logic [RA_W-1:0] in_rs2;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [RA_W-1:0] in_rd;
  logic            in_wb_en;

  logic [RA_W-1:0] ex_rd;
  logic            ex_wb_en;
  logic            ex_is_load;
  logic [XLEN-1:0] ex_result;
  logic [RA_W-1:0] wb_rd;
  logic            wb_en;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [RA_W-1:0] out_rd;
  logic            out_wb_en;
  logic            out_illegal;

  modport master (
    output in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
           in_imm, in_use_imm, in_rd, in_wb_en,
           ex_rd, ex_wb_en, ex_is_load, ex_result, wb_rd, wb_en, wb_data,
           flush, out_ready,
    input  in_ready, out_valid, alu_ctrl, alu_a, alu_b, out_rd, out_wb_en, out_illegal
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
           in_imm, in_use_imm, in_rd, in_wb_en,
           ex_rd, ex_wb_en, ex_is_load, ex_result, wb_rd, wb_en, wb_data,
           flush, out_ready,
    output in_ready, out_valid, alu_ctrl, alu_a, alu_b, out_rd, out_wb_en, out_illegal
  );
endinterface

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with operand select and load-use/RAW bubble insertion.
// Define IDEX_FWD_EN for ex/wb forwarding; without it every used-source match with ex or wb stalls.
module idex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic        clk,
  input logic        rst,
  idex_stage_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q;
  logic [3:0]      aluCtrl_q;
  logic [XLEN-1:0] aluA_q;
  logic [XLEN-1:0] aluB_q;
  logic [RA_W-1:0] rd_q;
  logic            wbEn_q;
  logic            illegal_q;

  logic            rs1Used, rs2Used;
  logic            rs1ExHit, rs2ExHit, rs1WbHit, rs2WbHit;
  logic            hazard, stageFree, capture, illegalOp;
  logic [XLEN-1:0] opA_d, opB_d;

  // x0 never matches; rs2 is ignored when B comes from the immediate
  assign rs1Used  = (bus.in_rs1 != '0);
  assign rs2Used  = !bus.in_use_imm && (bus.in_rs2 != '0);
  assign rs1ExHit = rs1Used && bus.ex_wb_en && (bus.in_rs1 == bus.ex_rd);
  assign rs2ExHit = rs2Used && bus.ex_wb_en && (bus.in_rs2 == bus.ex_rd);
  assign rs1WbHit = rs1Used && bus.wb_en && (bus.in_rs1 == bus.wb_rd);
  assign rs2WbHit = rs2Used && bus.wb_en && (bus.in_rs2 == bus.wb_rd);

`ifdef IDEX_FWD_EN
  assign hazard = bus.in_valid && bus.ex_is_load && (rs1ExHit || rs2ExHit);

  // ex has priority over wb; a loading ex match is a hazard so its value is never used
  always_comb begin
    opA_d = bus.in_rs1_val;
    if (rs1ExHit && !bus.ex_is_load) opA_d = bus.ex_result;
    else if (rs1WbHit)               opA_d = bus.wb_data;
    opB_d = bus.in_rs2_val;
    if (bus.in_use_imm)                   opB_d = bus.in_imm;
    else if (rs2ExHit && !bus.ex_is_load) opB_d = bus.ex_result;
    else if (rs2WbHit)                    opB_d = bus.wb_data;
  end
`else
  logic unusedFwd;

  assign hazard    = bus.in_valid && (rs1ExHit || rs2ExHit || rs1WbHit || rs2WbHit);
  assign opA_d     = bus.in_rs1_val;
  assign opB_d     = bus.in_use_imm ? bus.in_imm : bus.in_rs2_val;
  assign unusedFwd = ^{bus.ex_result, bus.wb_data, bus.ex_is_load};
`endif

  assign stageFree    = (state_q == EMPTY) || bus.out_ready;
  assign bus.in_ready = stageFree && !hazard && !bus.flush;
  assign capture      = bus.in_valid && bus.in_ready;
  assign illegalOp    = (bus.in_alu_ctrl > 4'hB);

  // Flush beats capture and hold; a free stage with nothing captured drains to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      aluCtrl_q <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      rd_q      <= '0;
      wbEn_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      state_q <= EMPTY;
      wbEn_q  <= 1'b0;
    end else if (capture) begin
      state_q   <= FULL;
      aluCtrl_q <= bus.in_alu_ctrl;
      aluA_q    <= opA_d;
      aluB_q    <= opB_d;
      rd_q      <= bus.in_rd;
      wbEn_q    <= bus.in_wb_en && !illegalOp;
      illegal_q <= illegalOp;
    end else if (stageFree) begin
      state_q <= EMPTY;
      wbEn_q  <= 1'b0;
    end
  end

  assign bus.out_valid   = (state_q == FULL);
  assign bus.alu_ctrl    = aluCtrl_q;
  assign bus.alu_a       = aluA_q;
  assign bus.alu_b       = aluB_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wb_en   = wbEn_q;
  assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed and randomized checks of idex_stage against an in-bench behavioural model.
// Works in both builds; IDEX_FWD_EN selects the forwarding or stall-only expectations.
`timescale 1ns/1ps
module tb_idex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic            mValid;
  logic [3:0]      mCtrl;
  logic [XLEN-1:0] mA, mB;
  logic [RA_W-1:0] mRd;
  logic            mWbEn, mIll;

  always #5 clk = ~clk;

  idex_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();
  idex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] ctrl,
                               input logic [RA_W-1:0] rs1, input logic [XLEN-1:0] rs1Val,
                               input logic [RA_W-1:0] rs2, input logic [XLEN-1:0] rs2Val,
                               input logic [XLEN-1:0] imm, input logic useImm,
                               input logic [RA_W-1:0] rd, input logic wbEn);
    bus.in_valid = v;      bus.in_alu_ctrl = ctrl;
    bus.in_rs1 = rs1;      bus.in_rs1_val = rs1Val;
    bus.in_rs2 = rs2;      bus.in_rs2_val = rs2Val;
    bus.in_imm = imm;      bus.in_use_imm = useImm;
    bus.in_rd = rd;        bus.in_wb_en = wbEn;
  endtask

  task automatic setBypass(input logic [RA_W-1:0] exRd, input logic exWbEn, input logic exLoad,
                           input logic [XLEN-1:0] exRes, input logic [RA_W-1:0] wbRd,
                           input logic wbEn, input logic [XLEN-1:0] wbData);
    bus.ex_rd = exRd;  bus.ex_wb_en = exWbEn; bus.ex_is_load = exLoad; bus.ex_result = exRes;
    bus.wb_rd = wbRd;  bus.wb_en = wbEn;      bus.wb_data = wbData;
  endtask

  task automatic resetModel();
    mValid = 1'b0; mCtrl = '0; mA = '0; mB = '0; mRd = '0; mWbEn = 1'b0; mIll = 1'b0;
  endtask

  // Value an operand must take for register r given its register-file read value
  function automatic logic [XLEN-1:0] srcValue(input logic [RA_W-1:0] r, input logic [XLEN-1:0] rf);
    if (r == '0) return rf;
`ifdef IDEX_FWD_EN
    if (bus.ex_wb_en && !bus.ex_is_load && r == bus.ex_rd) return bus.ex_result;
    if (bus.wb_en && r == bus.wb_rd) return bus.wb_data;
`endif
    return rf;
  endfunction

  function automatic logic modelStall();
    logic [RA_W-1:0] used[$];
    if (!bus.in_valid) return 1'b0;
    if (bus.in_rs1 != '0) used.push_back(bus.in_rs1);
    if (!bus.in_use_imm && bus.in_rs2 != '0) used.push_back(bus.in_rs2);
    foreach (used[k]) begin
      if (bus.ex_wb_en && bus.ex_is_load && used[k] == bus.ex_rd) return 1'b1;
`ifndef IDEX_FWD_EN
      if (bus.ex_wb_en && used[k] == bus.ex_rd) return 1'b1;
      if (bus.wb_en && used[k] == bus.wb_rd) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic modelReady();
    return (!mValid || bus.out_ready) && !modelStall() && !bus.flush;
  endfunction

  task automatic compareModel();
    checkBit("out_valid", bus.out_valid, mValid);
    if (mValid) begin
      checkOutput("alu_ctrl", 32'(bus.alu_ctrl), 32'(mCtrl));
      checkOutput("alu_a", bus.alu_a, mA);
      checkOutput("alu_b", bus.alu_b, mB);
      checkOutput("out_rd", 32'(bus.out_rd), 32'(mRd));
      checkBit("out_wb_en", bus.out_wb_en, mWbEn);
      checkBit("out_illegal", bus.out_illegal, mIll);
    end
  endtask

  // One clock: check in_ready, advance the model at the edge, then check outputs
  task automatic tick();
    logic rdy;
    #1;
    rdy = modelReady();
    checkBit("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    if (bus.flush) begin
      mValid = 1'b0;
    end else if (bus.in_valid && rdy) begin
      mValid = 1'b1;
      mCtrl  = bus.in_alu_ctrl;
      mA     = srcValue(bus.in_rs1, bus.in_rs1_val);
      mB     = bus.in_use_imm ? bus.in_imm : srcValue(bus.in_rs2, bus.in_rs2_val);
      mRd    = bus.in_rd;
      mIll   = (bus.in_alu_ctrl > 4'd11);
      mWbEn  = bus.in_wb_en && !mIll;
    end else if (!mValid || bus.out_ready) begin
      mValid = 1'b0;
      mWbEn  = 1'b0;
    end
    #1 compareModel();
    @(negedge clk);
  endtask

  initial begin
    logic holding, holdNext;
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 5'd0, '0, 5'd0, '0, '0, 1'b0, 5'd0, 1'b0);
    setBypass(5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, '0);
    bus.out_ready = 1'b1;
    bus.flush = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkBit("reset out_valid", bus.out_valid, 1'b0);
    checkBit("reset in_ready", bus.in_ready, 1'b1);

    // back-to-back immediate ops
    applyStimulus(1'b1, 4'h0, 5'd1, 32'hB5, 5'd2, 32'h0, 32'hD, 1'b1, 5'd4, 1'b1);
    tick();
    checkOutput("b2b alu_a", bus.alu_a, 32'hB5);
    checkOutput("b2b alu_b", bus.alu_b, 32'hD);
    checkBit("b2b out_valid", bus.out_valid, 1'b1);
    applyStimulus(1'b1, 4'h1, 5'd1, 32'h10, 5'd2, 32'h0, 32'h20, 1'b1, 5'd5, 1'b1);
    tick();
    checkOutput("b2b2 alu_a", bus.alu_a, 32'h10);
    checkOutput("b2b2 alu_ctrl", 32'(bus.alu_ctrl), 32'h1);
    checkBit("b2b2 out_valid", bus.out_valid, 1'b1);

    // ex and wb both match rs1
    applyStimulus(1'b1, 4'h2, 5'd3, 32'h77, 5'd0, 32'h0, 32'h1, 1'b1, 5'd6, 1'b1);
    setBypass(5'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h5);
`ifdef IDEX_FWD_EN
    tick();
    checkOutput("ex fwd alu_a", bus.alu_a, 32'hFFFF_FFFF);
`else
    #1 checkBit("raw stall in_ready", bus.in_ready, 1'b0);
    tick();
    setBypass(5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, '0);
    tick();
    checkOutput("raw stall alu_a", bus.alu_a, 32'h77);
`endif
    applyStimulus(1'b1, 4'h2, 5'd0, 32'h99, 5'd0, 32'h0, 32'h1, 1'b1, 5'd6, 1'b1);
    setBypass(5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h5);
    tick();
    checkOutput("x0 alu_a", bus.alu_a, 32'h99);

    // load-use on rs2
    applyStimulus(1'b1, 4'h3, 5'd1, 32'h1, 5'd7, 32'h11, 32'h0, 1'b0, 5'd8, 1'b1);
    setBypass(5'd7, 1'b1, 1'b1, 32'hDEAD, 5'd0, 1'b0, '0);
    #1 checkBit("load-use in_ready", bus.in_ready, 1'b0);
    tick();
    checkBit("load-use bubble", bus.out_valid, 1'b0);
    setBypass(5'd0, 1'b0, 1'b0, '0, 5'd7, 1'b1, 32'h42);
`ifdef IDEX_FWD_EN
    tick();
    checkOutput("load-use alu_b", bus.alu_b, 32'h42);
`else
    #1 checkBit("wb stall in_ready", bus.in_ready, 1'b0);
    tick();
    setBypass(5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, '0);
    tick();
    checkOutput("wb stall alu_b", bus.alu_b, 32'h11);
`endif
    checkBit("load-use valid", bus.out_valid, 1'b1);

    // backpressure then flush
    setBypass(5'd0, 1'b0, 1'b0, '0, 5'd0, 1'b0, '0);
    applyStimulus(1'b1, 4'h5, 5'd1, 32'hAA, 5'd2, 32'hBB, 32'h0, 1'b0, 5'd9, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'h6, 5'd1, 32'hCC, 5'd2, 32'hDD, 32'h0, 1'b0, 5'd10, 1'b1);
    repeat (3) begin
      tick();
      checkOutput("hold alu_a", bus.alu_a, 32'hAA);
      checkOutput("hold alu_ctrl", 32'(bus.alu_ctrl), 32'h5);
    end
    bus.flush = 1'b1;
    tick();
    checkBit("flush out_valid", bus.out_valid, 1'b0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkBit("flush dropped", bus.out_valid, 1'b0);

    // illegal opcode
    applyStimulus(1'b1, 4'hE, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd5, 1'b1);
    tick();
    checkBit("illegal flag", bus.out_illegal, 1'b1);
    checkBit("illegal wb_en", bus.out_wb_en, 1'b0);

    // reset while full and stalled
    applyStimulus(1'b1, 4'h7, 5'd1, 32'h1234, 5'd2, 32'h2, 32'h0, 1'b0, 5'd3, 1'b1);
    tick();
    checkOutput("pre-reset alu_a", bus.alu_a, 32'h1234);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkBit("rst out_valid", bus.out_valid, 1'b0);
    checkOutput("rst alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
    checkOutput("rst alu_a", bus.alu_a, 32'h0);
    checkOutput("rst alu_b", bus.alu_b, 32'h0);
    checkOutput("rst out_rd", 32'(bus.out_rd), 32'h0);
    checkBit("rst out_wb_en", bus.out_wb_en, 1'b0);
    checkBit("rst out_illegal", bus.out_illegal, 1'b0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    #1 checkBit("post-reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // randomized traffic; a stalled instruction is held until accepted or flushed
    holding = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!holding)
        applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                      5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                      $urandom, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                      ($urandom_range(0, 1) == 1));
      setBypass(5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                $urandom, 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      holdNext = bus.in_valid && !modelReady() && !bus.flush;
      tick();
      holding = holdNext;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idex_stage.md
# idex_stage

Pipeline register and operand-select stage directly upstream of the `alu`. Captures one decoded instruction per handshake, resolves operand A/B from the register file, immediate, or forwarding paths, and presents a registered `ALU_ctrl`/`A`/`B` triple to the ALU. It also detects load-use and RAW hazards and inserts bubbles, so the ALU only ever sees valid, hazard-free operands.

## Interface
- `XLEN`, 32, operand/result width (ALU is 32-bit)
- `RA_W`, 5, register address width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decode has an instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_alu_ctrl`  in  4  ALU opcode, 0x0–0xB legal
- `in_rs1`, `in_rs2`  in  RA_W  source register numbers
- `in_rs1_val`, `in_rs2_val`  in  XLEN  register-file read data
- `in_imm`  in  XLEN  sign-extended immediate
- `in_use_imm`  in  1  B comes from `in_imm`; rs2 is unused
- `in_rd`  in  RA_W  destination register
- `in_wb_en`  in  1  instruction writes `in_rd`
- `ex_rd`, `ex_wb_en`, `ex_is_load`  in  RA_W/1/1  instruction now in ALU stage
- `ex_result`  in  XLEN  ALU `result` feedback
- `wb_rd`, `wb_en`, `wb_data`  in  RA_W/1/XLEN  writeback port
- `flush`  in  1  kill held and incoming instruction
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  ALU stage accepts
- `alu_ctrl`  out  4  to ALU `ALU_ctrl`
- `alu_a`, `alu_b`  out  XLEN  to ALU `A`, `B`
- `out_rd`, `out_wb_en`  out  RA_W/1  carried to writeback
- `out_illegal`  out  1  captured opcode was 0xC–0xF

## Operation
- Register x0 never matches a hazard or forward source. A rs2 match is ignored when `in_use_imm`=1.
- Operand A source: `ex_result` if rs1==ex_rd && ex_wb_en && !ex_is_load. Else `wb_data` if rs1==wb_rd && wb_en. Else `in_rs1_val`. Operand B uses the same rule on rs2, and is overridden by `in_imm` when `in_use_imm`=1.
- `hazard` = in_valid && ex_wb_en && ex_is_load && rs1/rs2 (used) == ex_rd.
- `in_ready` = (!out_valid || out_ready) && !hazard && !flush.
- Capture when in_valid && in_ready: all fields registered, `out_valid`←1, `out_illegal`←(in_alu_ctrl > 0xB).
- Illegal opcodes still pass to the ALU with `out_wb_en` forced to 0.
- On a hazard, when the ALU stage frees up (!out_valid || out_ready), the stage loads a bubble: `out_valid`←0, `out_wb_en`←0. Decode holds its inputs stable until `in_ready`.
- Output hold: while out_valid && !out_ready, all outputs are frozen.
- States: EMPTY (out_valid=0), FULL (out_valid=1). EMPTY→FULL on capture. FULL→EMPTY on out_ready with no capture, on bubble, or on flush. FULL→FULL on simultaneous accept and capture.

## Timing
- Latency: 1 cycle from capture edge to `out_valid`. Throughput is 1 instruction/cycle with no hazard.
- Forward selection is combinational on inputs and sampled at the capture edge. Forwarded data is never updated while the stage holds.
- A load-use hazard costs exactly 1 bubble cycle when `ex_is_load` clears the following cycle.
- `flush` is synchronous: `out_valid`=0 the next cycle, the incoming instruction is dropped, and flush wins over capture and hold.
- Reset (asynchronous, any time, including mid-stall) drives all outputs to 0: `out_valid`, `alu_ctrl`, `alu_a`, `alu_b`, `out_rd`, `out_wb_en`, `out_illegal`. `in_ready` is 1 after reset release.
- Simultaneous ex and wb match on the same register: ex wins.

## Configuration
- `IDEX_FWD_EN` defined: forwarding muxes as above.
- `IDEX_FWD_EN` undefined: no forwarding. `hazard` additionally asserts on any used-source match with ex (ex_wb_en) or wb (wb_en). Operands always come from `in_rs*_val`/`in_imm`. Outputs are otherwise identical.

## Test plan
- Reset mid-FULL with `alu_a`=0x1234 -> all outputs 0 immediately, `in_ready`=1 after release.
- Back-to-back ops: ctrl=0x0, rs1_val=0xB5, imm=0xD, use_imm=1 -> next cycle `alu_a`=0xB5, `alu_b`=0xD, `out_valid`=1. Continuous 1/cycle.
- EX forward: rs1=3, ex_rd=3, ex_result=0xFFFFFFFF, wb_rd=3, wb_data=0x5 -> `alu_a`=0xFFFFFFFF. Repeat with rs1=0 -> `in_rs1_val`.
- Load-use: ex_is_load=1, ex_rd=rs2=7 -> `in_ready`=0 one cycle and one bubble; then capture with wb forward 0x42 -> `alu_b`=0x42.
- Backpressure plus flush: out_ready=0 for 3 cycles -> outputs frozen; flush with in_valid=1 -> `out_valid`=0 next cycle, instruction dropped.
- Illegal ctrl=0xE, in_wb_en=1 -> `out_illegal`=1, `out_wb_en`=0. Without `IDEX_FWD_EN`, a wb match stalls until wb_en drops.
